// File: rtl/brpred_pkg.sv
// Shared types and index/tag helpers for the gshare/BTB branch predictor.
// The helpers also serve the pipeline fields that carry history down to EX.
package brpred_pkg;

  // Fields are sized for the widest legal configuration; unused upper tag bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Weakly-not-taken reset value of a width-bit saturating counter.
  function automatic int unsigned cnt_init(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // PHT/BTB index: halfword pc bits, optionally hashed with history, masked to nbits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input logic [31:0] hist,
                                           input int unsigned nbits, input bit gshare);
    logic [31:0] mask;
    mask = (32'd1 << nbits) - 32'd1;
    return ((pc >> 1) ^ (gshare ? hist : 32'd0)) & mask;
  endfunction

  // BTB tag: the tbits pc bits sitting directly above the index bits (tbits < 32).
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned nbits,
                                         input int unsigned tbits);
    logic [31:0] mask;
    mask = (32'd1 << tbits) - 32'd1;
    return (pc >> (nbits + 1)) & mask;
  endfunction

endpackage

// File: rtl/brpred_sat_cnt_table.sv
// 2^N x CNT_WIDTH saturating counter table: one async read port, one update port.
module brpred_sat_cnt_table
  import brpred_pkg::*;
#(
  parameter int unsigned NUM_INDEX_BIT = 4,
  parameter int unsigned CNT_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_INDEX_BIT-1:0] rd_idx,
  output logic [CNT_WIDTH-1:0]     rd_cnt,
  input  logic                     upd_en,
  input  logic [NUM_INDEX_BIT-1:0] upd_idx,
  input  logic                     upd_taken
);

  localparam int unsigned          DEPTH = 1 << NUM_INDEX_BIT;
  localparam logic [CNT_WIDTH-1:0] INIT  = CNT_WIDTH'(cnt_init(CNT_WIDTH));
  localparam logic [CNT_WIDTH:0]   MAXV  = {1'b0, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] cnt [DEPTH];
  logic [CNT_WIDTH:0]   cur;

  assign rd_cnt = cnt[rd_idx];
  assign cur    = {1'b0, cnt[upd_idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= INIT;
    end else if (upd_en) begin
      if (upd_taken && (cur < MAXV))
        cnt[upd_idx] <= cnt[upd_idx] + 1'b1;
      else if (!upd_taken && (cur != '0))
        cnt[upd_idx] <= cnt[upd_idx] - 1'b1;
    end
  end

endmodule

// File: rtl/brpred_gshare_btb.sv
// IF-stage branch predictor: PHT (local or gshare indexed), tagged BTB and a
// speculative global history register repaired from EX on a mispredict.
module brpred_gshare_btb
  import brpred_pkg::*;
#(
  parameter int unsigned NUM_INDEX_BIT = 4,
  parameter int unsigned CNT_WIDTH     = 2,
  parameter int unsigned HIST_LEN      = 4,
  parameter int unsigned TAG_WIDTH     = 8,
  parameter bit          GSHARE        = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic [31:0]         lkp_pc_i,
  input  logic                lkp_branch_i,
  output logic                pred_taken_o,
  output logic [31:0]         pred_target_o,
  output logic                btb_hit_o,
  output logic [HIST_LEN-1:0] lkp_hist_o,
  input  logic                upd_valid_i,
  input  logic [31:0]         upd_pc_i,
  input  logic [HIST_LEN-1:0] upd_hist_i,
  input  logic                upd_taken_i,
  input  logic [31:0]         upd_target_i,
  input  logic                upd_miss_i
);

  localparam int unsigned DEPTH = 1 << NUM_INDEX_BIT;

  logic [HIST_LEN-1:0]      ghr;
  logic [31:0]              lkp_idx_full, lkp_pidx_full, upd_idx_full, upd_pidx_full;
  logic [31:0]              lkp_tag, upd_tag;
  logic [NUM_INDEX_BIT-1:0] lkp_idx, lkp_pidx, upd_idx, upd_pidx;
  logic [CNT_WIDTH-1:0]     lkp_cnt;
  btb_entry_t               btb [DEPTH];
  btb_entry_t               lkp_ent;
  logic                     unused_bits;

  assign lkp_idx_full  = pc_index(lkp_pc_i, 32'(ghr), NUM_INDEX_BIT, GSHARE);
  assign lkp_pidx_full = pc_index(lkp_pc_i, 32'd0, NUM_INDEX_BIT, 1'b0);
  assign upd_idx_full  = pc_index(upd_pc_i, 32'(upd_hist_i), NUM_INDEX_BIT, GSHARE);
  assign upd_pidx_full = pc_index(upd_pc_i, 32'd0, NUM_INDEX_BIT, 1'b0);
  assign lkp_tag       = pc_tag(lkp_pc_i, NUM_INDEX_BIT, TAG_WIDTH);
  assign upd_tag       = pc_tag(upd_pc_i, NUM_INDEX_BIT, TAG_WIDTH);

  assign lkp_idx  = lkp_idx_full[NUM_INDEX_BIT-1:0];
  assign lkp_pidx = lkp_pidx_full[NUM_INDEX_BIT-1:0];
  assign upd_idx  = upd_idx_full[NUM_INDEX_BIT-1:0];
  assign upd_pidx = upd_pidx_full[NUM_INDEX_BIT-1:0];

  assign unused_bits = ^{lkp_idx_full[31:NUM_INDEX_BIT], lkp_pidx_full[31:NUM_INDEX_BIT],
                         upd_idx_full[31:NUM_INDEX_BIT], upd_pidx_full[31:NUM_INDEX_BIT]};

  brpred_sat_cnt_table #(
    .NUM_INDEX_BIT (NUM_INDEX_BIT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lkp_idx),
    .rd_cnt    (lkp_cnt),
    .upd_en    (upd_valid_i & ~stall_i),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken_i)
  );

  // The BTB always uses the pc-only index so a target survives history changes.
  assign lkp_ent       = btb[lkp_pidx];
  assign btb_hit_o     = lkp_ent.valid && (lkp_ent.tag == lkp_tag);
  assign pred_taken_o  = lkp_branch_i & btb_hit_o & lkp_cnt[CNT_WIDTH-1];
  assign pred_target_o = btb_hit_o ? lkp_ent.target : '0;
  assign lkp_hist_o    = ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) btb[i] <= '0;
    end else if (upd_valid_i && upd_taken_i && !stall_i) begin
      btb[upd_pidx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i};
    end
  end

  // Truncating cast keeps the newest HIST_LEN bits, which also covers HIST_LEN=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (!stall_i) begin
      if (upd_valid_i && upd_miss_i)
        ghr <= HIST_LEN'({upd_hist_i, upd_taken_i});
      else if (lkp_branch_i)
        ghr <= HIST_LEN'({ghr, pred_taken_o});
    end
  end

endmodule

// File: tb/tb_brpred_gshare_btb.sv
// Checks a pc-indexed and a gshare-indexed predictor instance against a
// behavioural model, with directed literal expectations followed by random traffic.
module tb_brpred_gshare_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] lkp_pc_i;
  logic        lkp_branch_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [3:0]  upd_hist_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_miss_i;

  logic        pt [2];
  logic [31:0] tg [2];
  logic        hit [2];
  logic [3:0]  hs [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit en     = 1'b0;

  int          m_pht [2][16];
  bit          m_val [2][16];
  int          m_tag [2][16];
  logic [31:0] m_tgt [2][16];
  int          m_ghr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    brpred_gshare_btb #(
      .NUM_INDEX_BIT (4),
      .CNT_WIDTH     (2),
      .HIST_LEN      (4),
      .TAG_WIDTH     (8),
      .GSHARE        (g == 1)
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .lkp_pc_i      (lkp_pc_i),
      .lkp_branch_i  (lkp_branch_i),
      .pred_taken_o  (pt[g]),
      .pred_target_o (tg[g]),
      .btb_hit_o     (hit[g]),
      .lkp_hist_o    (hs[g]),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_hist_i    (upd_hist_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .upd_miss_i    (upd_miss_i)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int g = 0; g < 2; g++) begin
      m_ghr[g] = 0;
      for (int i = 0; i < 16; i++) begin
        m_pht[g][i] = 1;
        m_val[g][i] = 1'b0;
        m_tag[g][i] = 0;
        m_tgt[g][i] = 32'd0;
      end
    end
  endfunction

  function automatic int midx(input int g, input logic [31:0] pc, input int hist);
    return int'((pc >> 1) & 32'hF) ^ ((g == 1) ? hist : 0);
  endfunction

  function automatic int mtag(input logic [31:0] pc);
    return int'((pc >> 5) & 32'hFF);
  endfunction

  function automatic void model_out(input int g, output bit t, output logic [31:0] tgt,
                                    output bit h, output int hist);
    int p;
    p    = int'((lkp_pc_i >> 1) & 32'hF);
    h    = m_val[g][p] && (m_tag[g][p] == mtag(lkp_pc_i));
    t    = lkp_branch_i && h && (m_pht[g][midx(g, lkp_pc_i, m_ghr[g])] >= 2);
    tgt  = h ? m_tgt[g][p] : 32'd0;
    hist = m_ghr[g];
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (en && rst_n === 1'b1 && !stall_i) begin
      for (int g = 0; g < 2; g++) begin
        bit t, h;
        logic [31:0] tgt;
        int hist, i, p;
        model_out(g, t, tgt, h, hist);
        if (upd_valid_i) begin
          i = midx(g, upd_pc_i, int'(upd_hist_i));
          if (upd_taken_i && m_pht[g][i] < 3) m_pht[g][i]++;
          else if (!upd_taken_i && m_pht[g][i] > 0) m_pht[g][i]--;
          if (upd_taken_i) begin
            p = int'((upd_pc_i >> 1) & 32'hF);
            m_val[g][p] = 1'b1;
            m_tag[g][p] = mtag(upd_pc_i);
            m_tgt[g][p] = upd_target_i;
          end
        end
        if (upd_valid_i && upd_miss_i) m_ghr[g] = ((int'(upd_hist_i) << 1) | int'(upd_taken_i)) & 15;
        else if (lkp_branch_i)         m_ghr[g] = ((m_ghr[g] << 1) | int'(t)) & 15;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int g = 0; g < 2; g++) begin
        bit t, h;
        logic [31:0] tgt;
        int hist;
        model_out(g, t, tgt, h, hist);
        chk($sformatf("model_taken[%0d]", g), 32'(pt[g]), 32'(t));
        chk($sformatf("model_hit[%0d]", g), 32'(hit[g]), 32'(h));
        chk($sformatf("model_target[%0d]", g), tg[g], tgt);
        chk($sformatf("model_hist[%0d]", g), 32'(hs[g]), 32'(hist));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input logic [3:0] h,
                         input bit t, input logic [31:0] tgt, input bit miss);
    upd_valid_i  = v;
    upd_pc_i     = pc;
    upd_hist_i   = h;
    upd_taken_i  = t;
    upd_target_i = tgt;
    upd_miss_i   = miss;
  endtask

  task automatic set_lkp(input bit br, input logic [31:0] pc);
    lkp_branch_i = br;
    lkp_pc_i     = pc;
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs = '{32'h100, 32'h104, 32'h120, 32'h13E, 32'h2A6, 32'h10A};
    rst_n   = 1'b0;
    stall_i = 1'b0;
    set_lkp(1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    en = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset-state lookup.
    set_lkp(1'b1, 32'h100);
    #1;
    chk("reset_taken", 32'(pt[0]), 32'd0);
    chk("reset_hit", 32'(hit[0]), 32'd0);
    chk("reset_hist", 32'(hs[1]), 32'd0);
    set_lkp(1'b0, 32'h100);

    // Two taken updates populate the BTB and push the counter to taken.
    set_upd(1'b1, 32'h100, 4'h0, 1'b1, 32'h140, 1'b0);
    repeat (2) step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b1, 32'h100);
    #1;
    chk("btb_hit_after_train", 32'(hit[0]), 32'd1);
    chk("taken_after_train", 32'(pt[0]), 32'd1);
    chk("target_after_train", tg[0], 32'h140);
    set_lkp(1'b0, 32'h100);

    // Saturate at 3, one not-taken stays taken, a second drops to not-taken.
    set_upd(1'b1, 32'h100, 4'h0, 1'b1, 32'h140, 1'b0);
    repeat (2) step();
    set_upd(1'b1, 32'h100, 4'h0, 1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b1, 32'h100);
    #1;
    chk("sat_high_still_taken", 32'(pt[0]), 32'd1);
    set_lkp(1'b0, 32'h100);
    set_upd(1'b1, 32'h100, 4'h0, 1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b1, 32'h100);
    #1;
    chk("cnt1_not_taken", 32'(pt[0]), 32'd0);

    // Same-cycle update is not bypassed to the lookup.
    set_upd(1'b1, 32'h100, 4'h0, 1'b1, 32'h140, 1'b0);
    #1;
    chk("no_bypass_old", 32'(pt[0]), 32'd0);
    step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("no_bypass_next", 32'(pt[0]), 32'd1);
    set_lkp(1'b0, 32'h100);

    // Saturate at 0: four not-taken then one taken leaves counter 1.
    set_upd(1'b1, 32'h104, 4'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) step();
    set_upd(1'b1, 32'h104, 4'h0, 1'b1, 32'h1C0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b1, 32'h104);
    #1;
    chk("sat_low_hit", 32'(hit[0]), 32'd1);
    chk("sat_low_not_taken", 32'(pt[0]), 32'd0);

    // Speculative shifts build GHR=1011, then a mispredict repair wins.
    set_lkp(1'b1, 32'h100); step();
    set_lkp(1'b1, 32'h200); step();
    set_lkp(1'b1, 32'h100); step();
    set_lkp(1'b1, 32'h100);
    step();
    chk("ghr_built", 32'(hs[0]), 32'hB);
    set_upd(1'b1, 32'h10A, 4'b0010, 1'b1, 32'h180, 1'b1);
    step();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b0, 32'h100);
    #1;
    chk("ghr_repair", 32'(hs[0]), 32'h5);

    // Same BTB slot, different tag.
    set_lkp(1'b1, 32'h120);
    #1;
    chk("alias_hit", 32'(hit[0]), 32'd0);
    chk("alias_target", tg[0], 32'd0);
    set_lkp(1'b0, 32'h120);

    // Stall freezes BTB, PHT and GHR.
    stall_i = 1'b1;
    set_lkp(1'b1, 32'h100);
    set_upd(1'b1, 32'h120, 4'h0, 1'b1, 32'h200, 1'b1);
    repeat (2) step();
    stall_i = 1'b0;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b0, 32'h120);
    #1;
    chk("stall_btb_hold", 32'(hit[0]), 32'd0);
    chk("stall_ghr_hold", 32'(hs[0]), 32'h5);

    // Asynchronous reset mid-update clears everything immediately.
    set_lkp(1'b1, 32'h100);
    set_upd(1'b1, 32'h13E, 4'h0, 1'b1, 32'h300, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hit", 32'(hit[0]), 32'd0);
    chk("async_rst_hist", 32'(hs[0]), 32'd0);
    step();
    rst_n = 1'b1;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_lkp(1'b1, 32'h13E);
    #1;
    chk("rst_discards_upd", 32'(hit[0]), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      stall_i = ($urandom_range(7) == 0);
      set_lkp($urandom_range(1) == 1,
              ($urandom_range(3) == 0) ? 32'($urandom_range(511)) << 1 : pcs[$urandom_range(5)]);
      set_upd($urandom_range(1) == 1,
              ($urandom_range(3) == 0) ? 32'($urandom_range(511)) << 1 : pcs[$urandom_range(5)],
              4'($urandom_range(15)), $urandom_range(1) == 1,
              32'($urandom) & 32'hFFFF_FFFE, $urandom_range(5) == 0);
      if ($urandom_range(299) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
